// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 word memory with independent read/write burst engines, fixed read latency.
module axi_mem_slave #(
   parameter int    DATA_WIDTH   = 32,
   parameter int    ADDR_WIDTH   = 32,
   parameter int    ID_WIDTH     = 4,
   parameter int    MEM_DEPTH    = 1024,
   parameter int    READ_LATENCY = 2,
   parameter string INIT_FILE    = ""
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awlock,
   input  logic [3:0]                s_axi_awcache,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ID_WIDTH-1:0]       s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arlock,
   input  logic [3:0]                s_axi_arcache,
   input  logic [2:0]                s_axi_arprot,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [ID_WIDTH-1:0]       s_axi_rid,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);
   localparam int OFF = $clog2(DATA_WIDTH/8);
   localparam int WW  = ADDR_WIDTH - OFF;
   localparam int IW  = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
   localparam int LW  = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_arlock, s_axi_arcache,
                            s_axi_arprot, s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

   r_state_t         r_state, r_next;
   logic [WW-1:0]    r_word, r_word_n;
   logic [7:0]       r_len, r_beat, r_beat_n;
   logic [1:0]       r_burst;
   logic             r_err, r_hs, ar_hs, r_start, r_step, r_load, r_oor;
   logic [LW-1:0]    r_cnt;

   always_comb begin
      ar_hs    = s_axi_arvalid && s_axi_arready;
      r_hs     = s_axi_rvalid && s_axi_rready;
      r_start  = r_state == R_WAIT && r_cnt == LW'(READ_LATENCY - 1);
      r_step   = r_hs && r_beat != r_len;
      r_load   = r_start || r_step;
      r_word_n = r_step && r_burst != 2'b00 ? r_word + 1'b1 : r_word;
      r_beat_n = r_step ? r_beat + 8'd1 : r_beat;
      r_oor    = r_word_n >= WW'(MEM_DEPTH);
      r_next   = r_state == R_IDLE ? (ar_hs ? R_WAIT : R_IDLE) :
                 r_state == R_WAIT ? (r_start ? R_DATA : R_WAIT) :
                 (r_hs && r_beat == r_len ? R_IDLE : R_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rid     <= '0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= 2'b00;
         s_axi_rlast   <= 1'b0;
         r_word        <= '0;
         r_len         <= '0;
         r_beat        <= '0;
         r_burst       <= 2'b00;
         r_err         <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_state       <= r_next;
         s_axi_arready <= r_next == R_IDLE;
         s_axi_rvalid  <= r_next == R_DATA;
         if (ar_hs) begin
            s_axi_rid <= s_axi_arid;
            r_word    <= s_axi_araddr[ADDR_WIDTH-1:OFF];
            r_len     <= s_axi_arlen;
            r_beat    <= '0;
            r_burst   <= s_axi_arburst;
            r_err     <= s_axi_arburst[1] || s_axi_arsize != 3'(OFF);
            r_cnt     <= '0;
         end else begin
            r_word <= r_word_n;
            r_beat <= r_beat_n;
            r_cnt  <= r_state == R_WAIT ? r_cnt + 1'b1 : r_cnt;
         end
         // registered read sees pre-write contents when a write hits the same word this edge
         if (r_load) begin
            s_axi_rdata <= r_oor ? '0 : mem[r_word_n[IW-1:0]];
            s_axi_rresp <= r_oor ? 2'b11 : r_err ? 2'b10 : 2'b00;
            s_axi_rlast <= r_beat_n == r_len;
         end
      end
   end

   w_state_t         w_state, w_next;
   logic [WW-1:0]    w_word;
   logic [7:0]       w_len, w_beat;
   logic [1:0]       w_burst;
   logic             w_slv, w_dec, w_slv_n, w_dec_n, w_hs, aw_hs, b_hs, w_fin, w_oor;

   always_comb begin
      aw_hs   = s_axi_awvalid && s_axi_awready;
      w_hs    = s_axi_wvalid && s_axi_wready;
      b_hs    = s_axi_bvalid && s_axi_bready;
      w_fin   = w_hs && w_beat == w_len;
      w_oor   = w_word >= WW'(MEM_DEPTH);
      w_dec_n = w_dec || (w_hs && w_oor);
      w_slv_n = w_slv || (w_hs && s_axi_wlast != (w_beat == w_len));
      w_next  = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                w_state == W_DATA ? (w_fin ? W_RESP : W_DATA) :
                (b_hs ? W_IDLE : W_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bid     <= '0;
         s_axi_bresp   <= 2'b00;
         w_word        <= '0;
         w_len         <= '0;
         w_beat        <= '0;
         w_burst       <= 2'b00;
         w_slv         <= 1'b0;
         w_dec         <= 1'b0;
      end else begin
         w_state       <= w_next;
         s_axi_awready <= w_next == W_IDLE;
         s_axi_wready  <= w_next == W_DATA;
         s_axi_bvalid  <= w_next == W_RESP;
         if (aw_hs) begin
            s_axi_bid <= s_axi_awid;
            w_word    <= s_axi_awaddr[ADDR_WIDTH-1:OFF];
            w_len     <= s_axi_awlen;
            w_beat    <= '0;
            w_burst   <= s_axi_awburst;
            w_slv     <= s_axi_awburst[1] || s_axi_awsize != 3'(OFF);
            w_dec     <= 1'b0;
         end else if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            w_word <= w_burst == 2'b00 ? w_word : w_word + 1'b1;
            w_slv  <= w_slv_n;
            w_dec  <= w_dec_n;
         end
         if (w_fin)
            s_axi_bresp <= w_dec_n ? 2'b11 : w_slv_n ? 2'b10 : 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs && !w_oor)
         for (int i = 0; i < DATA_WIDTH/8; i++)
            if (s_axi_wstrb[i]) mem[w_word[IW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
   end
endmodule
